// File: rtl/layer_seq_if.sv
// Stream interface of the layer sequencer: input-vector handshake and result handshake.
// The slave modport is the layer's view; the master modport is the neighbouring stage's view.
interface layer_seq_if #(
    parameter int IN_N       = 16,
    parameter int OUT_N      = 8,
    parameter int DATA_WIDTH = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [IN_N*DATA_WIDTH-1:0]  in_vec;
    logic                        relu_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_N*DATA_WIDTH-1:0] out_vec;

    modport slave (
        input  in_valid, in_vec, relu_en, out_ready,
        output in_ready, out_valid, out_vec
    );

    modport master (
        output in_valid, in_vec, relu_en, out_ready,
        input  in_ready, out_valid, out_vec
    );
endinterface

// File: rtl/layer_seq.sv
// Time-multiplexed fixed-point fully-connected layer: PAR MAC lanes sweep OUT_N/PAR neuron
// groups, one input element per cycle, then bias, shift, saturate and optional ReLU per group.
module layer_seq #(
    parameter int IN_N       = 16,
    parameter int OUT_N      = 8,
    parameter int PAR        = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    layer_seq_if.slave                           bus,
    input  logic [OUT_N*IN_N*DATA_WIDTH-1:0]     weights,
    input  logic [OUT_N*DATA_WIDTH-1:0]          biases,
    output logic                                 busy
);
    localparam int G  = OUT_N / PAR;
    localparam int KW = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

    if (OUT_N % PAR != 0) begin : g_bad_par
        $error("layer_seq: OUT_N must be a multiple of PAR");
    end
    if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(IN_N) + 1) begin : g_bad_acc
        $error("layer_seq: ACC_WIDTH too small for IN_N products");
    end

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FINISH, S_DONE} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [KW-1:0]                   r_k;
    logic [GW-1:0]                   r_g;
    logic signed [ACC_WIDTH-1:0]     r_acc [PAR];
    logic [IN_N*DATA_WIDTH-1:0]      r_x;
    logic                            r_relu;
    logic [OUT_N*DATA_WIDTH-1:0]     r_out_vec;

    logic                            w_accept;
    logic                            w_last_k;
    logic                            w_last_g;
    logic signed [DATA_WIDTH-1:0]    w_x_k;
    logic signed [DATA_WIDTH-1:0]    w_w   [PAR];
    logic signed [DATA_WIDTH-1:0]    w_b   [PAR];
    logic signed [PW-1:0]            w_p   [PAR];
    logic signed [ACC_WIDTH-1:0]     w_prod[PAR];
    logic signed [ACC_WIDTH-1:0]     w_t   [PAR];
    logic signed [ACC_WIDTH-1:0]     w_s   [PAR];
    logic signed [DATA_WIDTH-1:0]    w_res [PAR];

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_last_k = (r_k == KW'(IN_N - 1));
    assign w_last_g = (r_g == GW'(G - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept)      w_state_nxt = S_MAC;
            S_MAC:    if (w_last_k)      w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = w_last_g ? S_DONE : S_MAC;
            S_DONE:   if (bus.out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // in_ready is also gated by rst so nothing is accepted while reset is held
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE) && !rst;
        bus.out_valid = (r_state == S_DONE);
        bus.out_vec   = r_out_vec;
        busy          = (r_state != S_IDLE);
    end

    // Per-lane product for the current element and the FINISH-stage post-processing
    always_comb begin
        w_x_k = r_x[int'(r_k)*DATA_WIDTH +: DATA_WIDTH];
        for (int l = 0; l < PAR; l++) begin
            w_w[l]    = weights[((int'(r_g)*PAR + l)*IN_N + int'(r_k))*DATA_WIDTH +: DATA_WIDTH];
            w_b[l]    = biases[(int'(r_g)*PAR + l)*DATA_WIDTH +: DATA_WIDTH];
            w_p[l]    = PW'(w_x_k) * PW'(w_w[l]);
            w_prod[l] = ACC_WIDTH'(w_p[l]);
            w_t[l]    = r_acc[l] + (ACC_WIDTH'(w_b[l]) <<< FRAC_BITS);
            w_s[l]    = w_t[l] >>> FRAC_BITS;
            if (w_s[l] > SAT_MAX)      w_res[l] = SAT_MAX[DATA_WIDTH-1:0];
            else if (w_s[l] < SAT_MIN) w_res[l] = SAT_MIN[DATA_WIDTH-1:0];
            else                       w_res[l] = w_s[l][DATA_WIDTH-1:0];
            if (r_relu && w_res[l] < 0) w_res[l] = '0;
        end
    end

    // NOTE: the accumulator array is reset explicitly; a reset must leave no stale partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k       <= '0;
            r_g       <= '0;
            r_x       <= '0;
            r_relu    <= 1'b0;
            r_out_vec <= '0;
            for (int l = 0; l < PAR; l++) r_acc[l] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x    <= bus.in_vec;
                        r_relu <= bus.relu_en;
                        r_k    <= '0;
                        r_g    <= '0;
                        for (int l = 0; l < PAR; l++) r_acc[l] <= '0;
                    end
                end
                S_MAC: begin
                    for (int l = 0; l < PAR; l++) r_acc[l] <= r_acc[l] + w_prod[l];
                    r_k <= w_last_k ? '0 : r_k + 1'b1;
                end
                S_FINISH: begin
                    for (int l = 0; l < PAR; l++)
                        r_out_vec[(int'(r_g)*PAR + l)*DATA_WIDTH +: DATA_WIDTH] <= w_res[l];
                    if (!w_last_g) begin
                        r_g <= r_g + 1'b1;
                        r_k <= '0;
                        for (int l = 0; l < PAR; l++) r_acc[l] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq: hand-computed results, latency, handshake hold and mid-run reset.
module tb_layer_seq;
    localparam int IN_N = 16;
    localparam int OUT_N = 8;
    localparam int PAR = 2;
    localparam int DW = 8;
    localparam int LAT = (OUT_N / PAR) * (IN_N + 1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic [OUT_N*IN_N*DW-1:0]   weights;
    logic [OUT_N*DW-1:0]        biases;
    logic                       busy;
    int                         n_checks = 0;
    int                         n_errors = 0;

    layer_seq_if #(.IN_N(IN_N), .OUT_N(OUT_N), .DATA_WIDTH(DW)) bus ();

    layer_seq #(
        .IN_N(IN_N), .OUT_N(OUT_N), .PAR(PAR),
        .DATA_WIDTH(DW), .ACC_WIDTH(32), .FRAC_BITS(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .weights (weights),
        .biases  (biases),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic set_data(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
        for (int i = 0; i < IN_N; i++) bus.in_vec[i*DW +: DW] = x;
        for (int i = 0; i < OUT_N*IN_N; i++) weights[i*DW +: DW] = w;
        for (int i = 0; i < OUT_N; i++) biases[i*DW +: DW] = b;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept(input logic relu, input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.relu_en  = relu;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run(input logic relu, input logic [63:0] exp, input string tag);
        accept(relu, tag);
        wait_out(tag);
        check({tag, "_out_vec"}, bus.out_vec, exp);
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.relu_en   = 1'b0;
        bus.in_vec    = '0;
        weights       = '0;
        biases        = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_vec", bus.out_vec, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // acc=256, t=288, y=18
        set_data(8'd16, 8'd1, 8'd2);
        run(1'b0, rep(8'h12), "c1");

        // pre-saturation 256 and -256
        set_data(8'd16, 8'd16, 8'd0);
        run(1'b0, rep(8'h7F), "c2_pos");
        set_data(8'd16, 8'hF0, 8'd0);
        run(1'b0, rep(8'h80), "c2_neg");

        // acc=-256, t=-224, y=-14 or 0 under ReLU
        set_data(8'd16, 8'hFF, 8'd2);
        run(1'b0, rep(8'hF2), "c3_norelu");
        run(1'b1, rep(8'h00), "c3_relu");
        accept(1'b1, "c3_tog_on");
        bus.relu_en = 1'b0;
        wait_out("c3_tog_on");
        check("c3_tog_on_out_vec", bus.out_vec, rep(8'h00));
        drain("c3_tog_on");
        accept(1'b0, "c3_tog_off");
        bus.relu_en = 1'b1;
        wait_out("c3_tog_off");
        check("c3_tog_off_out_vec", bus.out_vec, rep(8'hF2));
        drain("c3_tog_off");
        bus.relu_en = 1'b0;

        // floor rounding of -1/16 and +1/16
        set_data(8'd0, 8'hFF, 8'd0);
        bus.in_vec[DW-1:0] = 8'd1;
        run(1'b0, rep(8'hFF), "c4_floor");
        set_data(8'd0, 8'd1, 8'd0);
        bus.in_vec[DW-1:0] = 8'd1;
        run(1'b0, rep(8'h00), "c4_pos");

        // hold the result for 20 cycles with a competing in_valid, then back-to-back
        set_data(8'd16, 8'd1, 8'd2);
        accept(1'b0, "c5");
        wait_out("c5");
        set_data(8'd16, 8'hFF, 8'd2);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("c5_hold_out_vec", bus.out_vec, rep(8'h12));
            check("c5_hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("c5_hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("c5_in_ready_after", 64'(bus.in_ready), 64'd1);
        check("c5_out_valid_after", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("c5_b2b_busy", 64'(busy), 64'd1);
        wait_out("c5_b2b");
        check("c5_b2b_out_vec", bus.out_vec, rep(8'hF2));
        drain("c5_b2b");

        // reset 30 cycles into a computation
        set_data(8'd16, 8'd1, 8'd2);
        accept(1'b0, "c6");
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("c6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("c6_rst_out_vec", bus.out_vec, 64'd0);
        check("c6_rst_busy", 64'(busy), 64'd0);
        check("c6_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(1'b0, rep(8'h12), "c6_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/layer_seq.md
Name: layer_seq

Overview:
- Time-multiplexed, fixed-point, fully-connected layer: y[o] = act(sat((sum_i x[i]*W[o][i] + (b[o] <<< FRAC_BITS)) >>> FRAC_BITS)).
- Instead of one parallel neuron per output, PAR MAC lanes process OUT_N/PAR neuron groups in turn, one input element per cycle.
- Adds valid/ready handshakes, saturation, a fractional-point shift and optional ReLU.
- Sits between layer stages in the NPU datapath.

Parameters:
- IN_N, 16, input vector length.
- OUT_N, 8, output vector length. OUT_N % PAR == 0 is required; elaboration error otherwise.
- PAR, 2, number of parallel MAC lanes. G = OUT_N/PAR groups.
- DATA_WIDTH, 8, signed element width for x, W, b and y.
- ACC_WIDTH, 32, signed accumulator width. Must be >= 2*DATA_WIDTH + clog2(IN_N) + 1.
- FRAC_BITS, 4, fractional bits in the Q format of x, W, b and y.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block can accept an input vector.
- in_vec  in  IN_N*DATA_WIDTH  packed signed input; element i at [i*DATA_WIDTH +: DATA_WIDTH].
- relu_en  in  1  apply ReLU to this vector; sampled at accept.
- weights  in  OUT_N*IN_N*DATA_WIDTH  W[o][i] at [(o*IN_N+i)*DATA_WIDTH +: DATA_WIDTH].
- biases  in  OUT_N*DATA_WIDTH  b[o] at [o*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_vec holds a complete result.
- out_ready  in  1  downstream accepts the result.
- out_vec  out  OUT_N*DATA_WIDTH  packed signed result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock clk; reset rst is asynchronous and active-high.
  - rst high forces state=IDLE, all counters and accumulators 0, out_valid=0, out_vec=0, busy=0, in_ready=0.
  - in_ready = (state==IDLE) && !rst.
  - Reset mid-computation aborts the vector with no output.
- Accept: occurs on a rising edge with in_valid && in_ready.
  - in_vec and relu_en are registered.
  - weights and biases are not registered. They must stay stable from accept until out_valid rises.
- FSM IDLE -> MAC:
  - On accept, group counter g=0, index k=0, and all PAR lane accumulators are cleared.
- MAC:
  - Runs IN_N cycles per group.
  - Each cycle, lane l accumulates acc_l += x[k]*W[g*PAR+l][k]. Full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH.
  - k increments each cycle. When k==IN_N-1, go to FINISH.
- FINISH: one cycle. For each lane, o = g*PAR+l:
  - t = acc_l + sign-extended b[o] <<< FRAC_BITS.
  - s = t >>> FRAC_BITS, an arithmetic shift (truncation toward -inf).
  - Saturate s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If relu_en is latched high and the saturated value < 0, the value becomes 0.
  - The result is written to out_vec slot o.
  - If g==G-1, go to DONE. Otherwise g++, k=0, clear accumulators, return to MAC.
- DONE:
  - out_valid=1, and out_vec is held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. out_valid drops the next cycle.
  - in_ready reasserts in that IDLE cycle; there is no accept/output overlap.
- Latency: out_valid rises exactly G*(IN_N+1) cycles after the accept edge (68 at defaults).
  - Throughput: at most one vector per G*(IN_N+1)+2 cycles.
- out_vec keeps its last value in IDLE and is overwritten slot-by-slot during the next computation.
- Accumulator overflow beyond ACC_WIDTH wraps. The ACC_WIDTH parameter constraint prevents it.
- in_valid during MAC, FINISH or DONE is ignored; in_ready is low.

Test Plan:
1. Defaults. All x=16, all W=1, all b=2, relu_en=0 -> acc=256, t=288, every y=18. out_valid exactly 68 cycles after accept.
2. All x=16, W=16, b=0 -> pre-sat 256 -> every y=127. Same with W=-16 -> every y=-128.
3. All x=16, W=-1, b=2: relu_en=0 -> y=-14; relu_en=1 -> y=0. relu_en toggled after accept has no effect.
4. Rounding. x[0]=1, others 0, W=-1, b=0 -> t=-1 -> y=-1 (floor). Same with W=1 -> y=0.
5. Handshake.
   - Hold out_ready=0 for 20 cycles after out_valid -> out_vec stable, in_ready=0, new in_valid ignored.
   - Raise out_ready -> in_ready=1 the cycle after the transfer, and a back-to-back second vector is accepted.
6. Assert rst for 1 cycle at cycle 30 of a computation -> out_valid=0, out_vec=0, busy=0 immediately. A fresh vector afterwards gives the case-1 result with correct latency.
